cdc_handshake_tx: RTL and testbench



---
 rtl/cdc_handshake_ack_sync.sv | 38 +++
 rtl/cdc_handshake_tx.sv | 125 ++++++++++++
 tb/tb_cdc_handshake_tx.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdc_handshake_ack_sync.sv
// ============================================================================
// Module   : cdc_handshake_ack_sync
// Brief    : Resettable multi-flop synchronizer for the far-domain acknowledge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cdc_handshake_ack_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic primed
);

    logic [STAGES-1:0] r_sync;
    logic [STAGES-1:0] r_fill;

    // The flops clear to 0 on reset, so sync_out is not trustworthy until
    // STAGES samples of the live input have reached the last flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_fill <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], async_in};
            r_fill <= {r_fill[STAGES-2:0], 1'b1};
        end
    end

    assign sync_out = r_sync[STAGES-1];
    assign primed   = r_fill[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/cdc_handshake_tx.sv
// ============================================================================
// Module   : cdc_handshake_tx
// Brief    : Source side of a 4-phase req/ack transfer of one WIDTH-bit word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cdc_handshake_tx #(
    parameter int WIDTH   = 8,
    parameter int STAGES  = 2,
    parameter int TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             xfer_req,
    output logic [WIDTH-1:0] xfer_data,
    input  logic             xfer_ack,
    output logic             busy,
    output logic             done,
    output logic             timeout
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_REL  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_req;
    logic             r_done;
    logic [WIDTH-1:0] r_data;
    logic             w_ack_s;
    logic             w_sync_primed;
    logic             w_accept;
    logic             w_phase_hold;

    cdc_handshake_ack_sync #(
        .STAGES (STAGES)
    ) u_ack_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (xfer_ack),
        .sync_out (w_ack_s),
        .primed   (w_sync_primed)
    );

    // A stale high ack must drain before a new request may be raised.
    assign in_ready = !rst && w_sync_primed && (r_state == ST_IDLE) && !w_ack_s;
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_REQ;
            ST_REQ:  if (w_ack_s)  w_state_nxt = ST_REL;
            ST_REL:  if (!w_ack_s) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_phase_hold = (r_state != ST_IDLE) && (w_state_nxt == r_state);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_done  <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= (w_state_nxt == ST_REQ);
            r_done  <= (r_state == ST_REL) && (w_state_nxt == ST_IDLE);
            if (w_accept) begin
                r_data <= in_data;
            end
        end
    end

    assign xfer_req  = r_req;
    assign xfer_data = r_data;
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;

    generate
        if (TIMEOUT > 0) begin : g_timeout
            localparam int CW = $clog2(TIMEOUT + 1);

            logic [CW-1:0] r_cnt;
            logic [CW-1:0] w_cnt_nxt;
            logic          r_timeout;

            // Count saturates so a stalled far end cannot wrap the flag off.
            always_comb begin
                w_cnt_nxt = '0;
                if (w_phase_hold) begin
                    w_cnt_nxt = (r_cnt == CW'(TIMEOUT)) ? r_cnt : r_cnt + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt     <= '0;
                    r_timeout <= 1'b0;
                end else begin
                    r_cnt <= w_cnt_nxt;
                    if (w_accept) begin
                        r_timeout <= 1'b0;
                    end else if (w_phase_hold && (w_cnt_nxt == CW'(TIMEOUT))) begin
                        r_timeout <= 1'b1;
                    end
                end
            end

            assign timeout = r_timeout;
        end else begin : g_no_timeout
            assign timeout = 1'b0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_cdc_handshake_tx.sv
// ============================================================================
// Module   : tb_cdc_handshake_tx
// Brief    : Directed and randomized-ratio bench for cdc_handshake_tx.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_cdc_handshake_tx;

    localparam int WIDTH   = 8;
    localparam int STAGES  = 2;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready;
    logic             xfer_req;
    logic [WIDTH-1:0] xfer_data;
    logic             xfer_ack;
    logic             busy;
    logic             done;
    logic             timeout;

    cdc_handshake_tx #(
        .WIDTH   (WIDTH),
        .STAGES  (STAGES),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .xfer_req  (xfer_req),
        .xfer_data (xfer_data),
        .xfer_ack  (xfer_ack),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // Far end: ack follows req three far-clock cycles later, or is forced.
    logic fclk = 1'b0;
    real  far_half = 5.0;
    logic [2:0] far_sr = 3'b000;
    logic far_force = 1'b1;
    logic far_val = 1'b0;

    initial begin
        #2.3;
        forever #(far_half) fclk = ~fclk;
    end

    always @(posedge fclk) far_sr <= {far_sr[1:0], xfer_req};

    assign xfer_ack = far_force ? far_val : far_sr[2];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor, sampled mid-cycle.
    logic             mon_en = 1'b0;
    logic [WIDTH-1:0] exp_q[$];
    int               acc_cnt = 0;
    int               done_cnt = 0;
    int               stab_err = 0;
    logic             prev_req = 1'b0;
    logic             prev_busy = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (done) begin
                done_cnt++;
                check("done_has_word", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) check("done_data", xfer_data, exp_q.pop_front());
            end
            if (xfer_req && !prev_req) begin
                check("req_rise_has_word", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) check("req_rise_data", xfer_data, exp_q[0]);
            end
            if (busy && prev_busy && (xfer_data !== prev_data)) stab_err++;
            if (!rst && in_valid && in_ready) begin
                exp_q.push_back(in_data);
                acc_cnt++;
            end
        end
        prev_req  = xfer_req;
        prev_busy = busy;
        prev_data = xfer_data;
    end

    logic [WIDTH-1:0] wd [3];
    int d, bad, idx, b2b, sent;

    initial begin
        wd[0] = 8'hA5; wd[1] = 8'h3C; wd[2] = 8'hFF;

        // Reset state
        rst = 1'b1;
        repeat (3) step;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_req", xfer_req, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        check("rst_data", xfer_data, 8'h00);
        rst = 1'b0;
        step; step;
        check("idle_in_ready", in_ready, 1'b1);

        // Single transfer through the far-end model
        far_force = 1'b0;
        in_valid = 1'b1; in_data = 8'hA5;
        step;
        in_valid = 1'b0; in_data = 8'h00;
        check("single_req_rise", xfer_req, 1'b1);
        check("single_data", xfer_data, 8'hA5);
        check("single_busy", busy, 1'b1);
        check("single_not_ready", in_ready, 1'b0);
        d = 0; bad = 0;
        for (int i = 0; i < 60; i++) begin
            step;
            if (done) d++;
            if (busy && xfer_data !== 8'hA5) bad++;
        end
        check("single_done_count", d, 1);
        check("single_data_stable", bad, 0);
        check("single_ready_back", in_ready, 1'b1);
        check("single_busy_end", busy, 1'b0);
        check("single_req_end", xfer_req, 1'b0);
        check("single_data_hold", xfer_data, 8'hA5);

        // Back-to-back stream with in_valid held high
        mon_en = 1'b1;
        idx = 0; b2b = 0;
        for (int c = 0; c < 300 && (idx < 3 || busy); c++) begin
            in_valid = (idx < 3);
            in_data  = (idx < 3) ? wd[idx] : 8'h00;
            if (in_valid && in_ready) begin
                if (done) b2b++;
                idx++;
            end
            step;
        end
        in_valid = 1'b0;
        repeat (3) step;
        mon_en = 1'b0;
        check("b2b_accepts", idx, 3);
        check("b2b_done_count", done_cnt, 3);
        check("b2b_accept_on_done", b2b, 2);
        check("b2b_queue_empty", exp_q.size(), 0);
        check("b2b_stable", stab_err, 0);

        // Stale ack held through reset
        far_force = 1'b1; far_val = 1'b1;
        rst = 1'b1;
        repeat (3) step;
        rst = 1'b0;
        in_valid = 1'b1; in_data = 8'h5A;
        bad = 0;
        repeat (10) begin
            step;
            if (in_ready || xfer_req) bad++;
        end
        check("stale_gate", bad, 0);
        far_val = 1'b0;
        step;
        check("stale_ready_sync1", in_ready, 1'b0);
        step;
        check("stale_ready_sync2", in_ready, 1'b1);
        step;
        in_valid = 1'b0;
        check("stale_accept_req", xfer_req, 1'b1);
        check("stale_accept_data", xfer_data, 8'h5A);
        far_val = 1'b1;
        step; step;
        check("ack_rise_req_hold", xfer_req, 1'b1);
        step;
        check("ack_rise_req_fall", xfer_req, 1'b0);
        far_val = 1'b0;
        step; step;
        check("ack_fall_no_done_yet", done, 1'b0);
        step;
        check("ack_fall_done", done, 1'b1);
        check("ack_fall_idle", busy, 1'b0);
        step;
        check("done_one_cycle", done, 1'b0);

        // Reset while in REQ
        in_valid = 1'b1; in_data = 8'h77;
        step;
        in_valid = 1'b0;
        check("mid_req_up", xfer_req, 1'b1);
        step; step;
        rst = 1'b1;
        step;
        check("mid_rst_req", xfer_req, 1'b0);
        check("mid_rst_data", xfer_data, 8'h00);
        check("mid_rst_busy", busy, 1'b0);
        rst = 1'b0;
        bad = 0;
        repeat (5) begin
            step;
            if (done) bad++;
        end
        check("mid_rst_no_done", bad, 0);
        in_valid = 1'b1; in_data = 8'h88;
        step;
        in_valid = 1'b0;
        check("recover_req", xfer_req, 1'b1);
        check("recover_data", xfer_data, 8'h88);
        far_val = 1'b1;
        repeat (3) step;
        check("recover_rel", xfer_req, 1'b0);
        far_val = 1'b0;
        repeat (3) step;
        check("recover_done", done, 1'b1);

        // Timeout with an unresponsive far end
        in_valid = 1'b1; in_data = 8'h11;
        step;
        in_valid = 1'b0;
        check("to_clear_at_start", timeout, 1'b0);
        repeat (15) step;
        check("to_before_limit", timeout, 1'b0);
        step;
        check("to_at_limit", timeout, 1'b1);
        repeat (10) step;
        check("to_sticky", timeout, 1'b1);
        check("to_req_held", xfer_req, 1'b1);
        far_val = 1'b1;
        repeat (3) step;
        check("to_rel", xfer_req, 1'b0);
        check("to_sticky_rel", timeout, 1'b1);
        far_val = 1'b0;
        repeat (3) step;
        check("to_done", done, 1'b1);
        in_valid = 1'b1; in_data = 8'h22;
        step;
        in_valid = 1'b0;
        check("to_cleared_by_accept", timeout, 1'b0);
        far_val = 1'b1;
        repeat (3) step;
        far_val = 1'b0;
        repeat (4) step;

        // Randomized far-clock ratio, 1000 words
        far_force = 1'b0;
        exp_q.delete();
        acc_cnt = 0; done_cnt = 0; stab_err = 0; sent = 0;
        mon_en = 1'b1;
        for (int c = 0; c < 80000 && sent < 1000; c++) begin
            if (c % 97 == 0) far_half = 1.67 + real'($urandom_range(0, 1500)) / 100.0;
            in_valid = ($urandom_range(0, 9) < 7);
            in_data  = 8'($urandom);
            if (in_valid && in_ready) sent++;
            step;
        end
        in_valid = 1'b0;
        for (int c = 0; c < 300 && busy; c++) step;
        repeat (3) step;
        mon_en = 1'b0;
        check("rand_sent", sent, 1000);
        check("rand_accepts", acc_cnt, 1000);
        check("rand_done_count", done_cnt, 1000);
        check("rand_queue_empty", exp_q.size(), 0);
        check("rand_stable", stab_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
